// File: rtl/int_ctrl_pkg.sv
// Shared constants, state encoding and priority helper for the interrupt controller.
package int_pkg;

  localparam int unsigned N_SRC       = 4;
  localparam int unsigned GEN_BIT_DEF = 31;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACKED = 2'd2
  } state_e;

  // Isolates the lowest set bit, so source 0 has the highest priority.
  function automatic logic [N_SRC-1:0] lowest_one(input logic [N_SRC-1:0] v);
    return v & (~v + N_SRC'(1));
  endfunction

endpackage

// File: rtl/int_ctrl_irq_sync_edge.sv
// Two-flop synchronizer for one interrupt line plus a rising-edge detect on the synchronized value.
module irq_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic irq_i,
  output logic s2_o,
  output logic rise_o
);

  logic s1_q, s2_q, prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= irq_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign s2_o   = s2_q;
  assign rise_o = s2_q & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: pending latch, masking, fixed priority and a four-phase Ireq/Iack handshake.
module int_ctrl
  import int_pkg::*;
#(
  parameter logic [N_SRC-1:0] EDGE_MASK = '1,
  parameter int unsigned      GEN_BIT   = GEN_BIT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_src,
  input  logic [31:0]      int_en,
  input  logic             Iack,
  output logic             Ireq,
  output logic [N_SRC-1:0] gntInt,
  output logic [N_SRC-1:0] pending_o,
  output logic [N_SRC-1:0] lost_o
);

  logic [N_SRC-1:0] s2, rise;
  logic [N_SRC-1:0] pend_q, pend_d, lost_q, lost_d, gnt_q, gnt_d;
  logic [N_SRC-1:0] eligible;
  logic             accept;
  logic             unused_en;
  state_e           state_q, state_d;

  for (genvar g = 0; g < N_SRC; g++) begin : g_sync
    irq_sync_edge u_sync (
      .clk_i  (clk),
      .rst_ni (reset),
      .irq_i  (irq_src[g]),
      .s2_o   (s2[g]),
      .rise_o (rise[g])
    );
  end

  assign unused_en = ^int_en;
  assign eligible  = pend_q & int_en[N_SRC-1:0] & {N_SRC{int_en[GEN_BIT]}};
  assign accept    = (state_q == REQ) && Iack;

  // A new edge in the accept cycle keeps the source pending.
  always_comb begin
    pend_d = pend_q;
    lost_d = lost_q;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (EDGE_MASK[i]) begin
        if (rise[i])                    pend_d[i] = 1'b1;
        else if (accept && gnt_q[i])    pend_d[i] = 1'b0;
        if (rise[i] && pend_q[i])       lost_d[i] = 1'b1;
      end else begin
        pend_d[i] = s2[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      pend_q  <= '0;
      lost_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      pend_q  <= pend_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (eligible != '0) begin
          gnt_d   = lowest_one(eligible);
          state_d = REQ;
        end
      end
      REQ: begin
        if (Iack) state_d = ACKED;
      end
      ACKED: begin
        if (!Iack) begin
          gnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    Ireq      = (state_q == REQ);
    gntInt    = gnt_q;
    pending_o = pend_q;
    lost_o    = lost_q;
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: an edge-mode and a level-mode instance, each checked every cycle against a behavioural model.
module tb_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq_e, irq_l;
  logic [31:0] en_e, en_l;
  logic        ack_e, ack_l;
  logic        ireq_e, ireq_l;
  logic [3:0]  gnt_e, gnt_l, pend_e, pend_l, lost_e, lost_l;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  int_ctrl #(.EDGE_MASK(4'b1111), .GEN_BIT(31)) dut_e (
    .clk(clk), .reset(reset), .irq_src(irq_e), .int_en(en_e), .Iack(ack_e),
    .Ireq(ireq_e), .gntInt(gnt_e), .pending_o(pend_e), .lost_o(lost_e)
  );

  int_ctrl #(.EDGE_MASK(4'b0000), .GEN_BIT(31)) dut_l (
    .clk(clk), .reset(reset), .irq_src(irq_l), .int_en(en_l), .Iack(ack_l),
    .Ireq(ireq_l), .gntInt(gnt_l), .pending_o(pend_l), .lost_o(lost_l)
  );

  // Model state: input sample history (newest first), pending/lost/grant vectors, handshake phase
  // (0 = idle, 1 = request raised, 2 = acknowledged, waiting for Iack to drop).
  logic [3:0] m_h0 [2], m_h1 [2], m_h2 [2];
  logic [3:0] m_pend [2], m_lost [2], m_gnt [2];
  int         m_phase [2];

  task automatic model_step(input int m);
    logic [3:0]  src, em, rise, elig, win, np;
    logic [31:0] en_v;
    logic        ack_v, accept;
    src  = (m == 0) ? irq_e : irq_l;
    en_v = (m == 0) ? en_e  : en_l;
    ack_v = (m == 0) ? ack_e : ack_l;
    em   = (m == 0) ? 4'b1111 : 4'b0000;
    if (!reset) begin
      m_h0[m] = '0; m_h1[m] = '0; m_h2[m] = '0;
      m_pend[m] = '0; m_lost[m] = '0; m_gnt[m] = '0; m_phase[m] = 0;
      return;
    end
    rise = m_h1[m] & ~m_h2[m];
    elig = m_pend[m] & en_v[3:0] & {4{en_v[31]}};
    win = '0;
    for (int i = 3; i >= 0; i--) if (elig[i]) win = 4'(1 << i);
    accept = (m_phase[m] == 1) && ack_v;
    np = m_pend[m];
    for (int i = 0; i < 4; i++) begin
      if (em[i]) begin
        if (rise[i]) begin
          if (m_pend[m][i]) m_lost[m][i] = 1'b1;
          np[i] = 1'b1;
        end else if (accept && m_gnt[m][i]) begin
          np[i] = 1'b0;
        end
      end else begin
        np[i] = m_h1[m][i];
      end
    end
    if (m_phase[m] == 0 && elig != 0) begin
      m_gnt[m] = win; m_phase[m] = 1;
    end else if (accept) begin
      m_phase[m] = 2;
    end else if (m_phase[m] == 2 && !ack_v) begin
      m_gnt[m] = '0; m_phase[m] = 0;
    end
    m_pend[m] = np;
    m_h2[m] = m_h1[m]; m_h1[m] = m_h0[m]; m_h0[m] = src;
  endtask

  always @(posedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("model_e_ireq", 32'(ireq_e), 32'(m_phase[0] == 1));
      chk("model_e_gnt",  32'(gnt_e),  32'(m_gnt[0]));
      chk("model_e_pend", 32'(pend_e), 32'(m_pend[0]));
      chk("model_e_lost", 32'(lost_e), 32'(m_lost[0]));
      chk("model_l_ireq", 32'(ireq_l), 32'(m_phase[1] == 1));
      chk("model_l_gnt",  32'(gnt_l),  32'(m_gnt[1]));
      chk("model_l_pend", 32'(pend_l), 32'(m_pend[1]));
      chk("model_l_lost", 32'(lost_l), 32'(m_lost[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_cycle(input int sel);
    if (sel == 0) ack_e = 1'b1; else ack_l = 1'b1;
    tick();
    if (sel == 0) ack_e = 1'b0; else ack_l = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b0;
    irq_e = '0; irq_l = '0;
    en_e = 32'h8000_000F; en_l = 32'h8000_000F;
    ack_e = 1'b0; ack_l = 1'b0;
    tick();
    mon_en = 1'b1;
    tick();
    chk("rst_ireq", 32'(ireq_e), 32'h0);
    chk("rst_gnt",  32'(gnt_e),  32'h0);
    chk("rst_pend", 32'(pend_e), 32'h0);
    chk("rst_lost", 32'(lost_e), 32'h0);
    reset = 1'b1;
    tick();

    // Single edge on source 2
    irq_e = 4'b0100; tick(); irq_e = '0;
    tick(); tick();
    chk("t1_pend_k2", 32'(pend_e), 32'h4);
    chk("t1_noreq_k2", 32'(ireq_e), 32'h0);
    tick();
    chk("t1_ireq_k3", 32'(ireq_e), 32'h1);
    chk("t1_gnt_k3",  32'(gnt_e),  32'h4);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t1_hold_ireq", 32'(ireq_e), 32'h1);
      chk("t1_hold_gnt",  32'(gnt_e),  32'h4);
    end
    ack_e = 1'b1; tick();
    chk("t1_ack_ireq", 32'(ireq_e), 32'h0);
    chk("t1_ack_pend", 32'(pend_e), 32'h0);
    ack_e = 1'b0; tick();
    chk("t1_idle_gnt", 32'(gnt_e), 32'h0);

    // Priority, no pre-emption
    irq_e = 4'b1010; tick(); tick(); tick(); tick();
    chk("t2_gnt_src1", 32'(gnt_e), 32'h2);
    irq_e = 4'b1011;
    repeat (4) tick();
    chk("t2_nopreempt", 32'(gnt_e), 32'h2);
    chk("t2_pend", 32'(pend_e), 32'hB);
    ack_cycle(0); tick();
    chk("t2_gnt_src0", 32'(gnt_e), 32'h1);
    ack_cycle(0); tick();
    chk("t2_gnt_src3", 32'(gnt_e), 32'h8);
    ack_cycle(0);
    irq_e = '0;
    repeat (3) tick();

    // Global enable off
    en_e = 32'h0000_000F;
    irq_e = 4'b0001; tick(); irq_e = '0;
    tick(); tick(); tick();
    chk("t3_noreq", 32'(ireq_e), 32'h0);
    chk("t3_pend",  32'(pend_e), 32'h1);
    en_e = 32'h8000_000F; tick();
    chk("t3_ireq", 32'(ireq_e), 32'h1);
    chk("t3_gnt",  32'(gnt_e),  32'h1);
    ack_cycle(0);
    tick();

    // Coalesced edges on source 1
    irq_e = 4'b0010; tick(); irq_e = '0; tick();
    irq_e = 4'b0010; tick(); irq_e = '0; tick();
    tick(); tick();
    chk("t4_lost", 32'(lost_e), 32'h2);
    chk("t4_gnt",  32'(gnt_e),  32'h2);
    ack_cycle(0); tick();
    chk("t4_one_grant", 32'(ireq_e), 32'h0);
    chk("t4_pend_clr",  32'(pend_e), 32'h0);

    // Edge coincident with the accept cycle
    irq_e = 4'b0010; tick(); irq_e = '0; tick(); tick(); tick();
    chk("t4_regrant_req", 32'(ireq_e), 32'h1);
    irq_e = 4'b0010; tick(); tick();
    ack_e = 1'b1; tick();
    chk("t4_set_wins", 32'(pend_e), 32'h2);
    ack_e = 1'b0; tick(); tick();
    chk("t4_second_ireq", 32'(ireq_e), 32'h1);
    chk("t4_second_gnt",  32'(gnt_e),  32'h2);
    ack_cycle(0);
    irq_e = '0; tick();
    chk("t4_final_pend", 32'(pend_e), 32'h0);

    // Level mode on the second instance
    irq_l = 4'b0100; tick(); tick(); tick(); tick();
    chk("t5_ireq", 32'(ireq_l), 32'h1);
    chk("t5_gnt",  32'(gnt_l),  32'h4);
    ack_cycle(1); tick();
    chk("t5_regrant", 32'(ireq_l), 32'h1);
    chk("t5_regnt",   32'(gnt_l),  32'h4);
    irq_l = '0;
    repeat (4) tick();
    chk("t5_held_ireq", 32'(ireq_l), 32'h1);
    chk("t5_held_gnt",  32'(gnt_l),  32'h4);
    chk("t5_pend_drop", 32'(pend_l), 32'h0);
    ack_cycle(1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t5_no_more", 32'(ireq_l), 32'h0);
    end

    // Reset in the middle of a handshake
    irq_e = 4'b0001; tick(); irq_e = '0; tick(); tick(); tick();
    chk("t6_in_req", 32'(ireq_e), 32'h1);
    irq_e = 4'b1000;
    reset = 1'b0; tick();
    chk("t6_ireq", 32'(ireq_e), 32'h0);
    chk("t6_gnt",  32'(gnt_e),  32'h0);
    chk("t6_pend", 32'(pend_e), 32'h0);
    chk("t6_lost", 32'(lost_e), 32'h0);
    reset = 1'b1;
    tick(); tick(); tick();
    chk("t6_not_yet", 32'(ireq_e), 32'h0);
    tick();
    chk("t6_ireq_after", 32'(ireq_e), 32'h1);
    chk("t6_gnt_after",  32'(gnt_e),  32'h8);
    ack_cycle(0);
    irq_e = '0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
